fpu_multiplier: RTL and testbench

- IEEE-754 binary32 multiplier with independent strobe/acknowledge handshakes on operand A, operand B and result Z.
- Multi-cycle state machine; one multiplication in flight at a time.
- Sits as the multiply unit of the FPU datapath used by the NN accelerator, between operand sequencers and an accumulator/consumer that may stall.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fpu_unpack.sv | 40 ++++
 rtl/fpu_multiplier.sv | 258 +++++++++++++++++++++++++
 tb/tb_fpu_multiplier.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the binary32 multiplier: FSM states,
// IEEE-754 special encodings and the unpacked-operand record.
package fpu_pkg;

    typedef enum logic [3:0] {
        GET_A,
        GET_B,
        UNPACK,
        SPECIAL,
        NORM_A,
        NORM_B,
        MUL,
        NORM_1,
        NORM_2,
        ROUND,
        PACK,
        PUT_Z
    } fpu_state_t;

    localparam logic [31:0] FP_QNAN  = 32'h7FC00000;
    localparam logic [31:0] FP_INF   = 32'h7F800000;
    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MIN  = -126;

    // 10-bit signed views of the exponent limits used by the datapath
    localparam logic signed [9:0] EXP_BIAS_W = 10'(EXP_BIAS);
    localparam logic signed [9:0] EXP_MIN_W  = 10'(EXP_MIN);
    localparam logic signed [9:0] EXP_MAX_W  = 10'(EXP_BIAS);

    typedef struct packed {
        logic              sign;
        logic signed [9:0] exp;
        logic [23:0]       mant;
    } fp_unpacked_t;

endpackage

// File: rtl/fpu_unpack.sv
// Splits a binary32 word into sign / unbiased exponent / mantissa and flags
// NaN, infinity and zero. Honours FPU_MUL_DENORM_EN for the zero test.
module fpu_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]  value,
    output fp_unpacked_t fields,
    output logic         is_nan,
    output logic         is_inf,
    output logic         is_zero
);

    logic [7:0]  exp_field;
    logic [22:0] frac;

    assign exp_field = value[30:23];
    assign frac      = value[22:0];

    always_comb begin
        fields.sign = value[31];
        if (exp_field == 8'h00) begin
            fields.exp  = EXP_MIN_W;
            fields.mant = {1'b0, frac};
        end else begin
            fields.exp  = $signed({2'b00, exp_field}) - EXP_BIAS_W;
            fields.mant = {1'b1, frac};
        end
    end

    assign is_nan = (exp_field == 8'hFF) && (frac != 23'd0);
    assign is_inf = (exp_field == 8'hFF) && (frac == 23'd0);

`ifdef FPU_MUL_DENORM_EN
    assign is_zero = (exp_field == 8'h00) && (frac == 23'd0);
`else
    // Without denormal support any zero-exponent operand collapses to zero
    assign is_zero = (exp_field == 8'h00);
`endif

endmodule

// File: rtl/fpu_multiplier.sv
// Multi-cycle IEEE-754 binary32 multiplier with strobe/ack handshakes on A, B, Z.
// Define FPU_MUL_DENORM_EN for full denormal handling; otherwise denormals flush to zero.
module fpu_multiplier
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    fpu_state_t        state_reg, state_next;
    logic [31:0]       a_raw_reg, a_raw_next;
    logic [31:0]       b_raw_reg, b_raw_next;
    logic              a_ack_reg, a_ack_next;
    logic              b_ack_reg, b_ack_next;
    fp_unpacked_t      a_u_reg, a_u_next;
    fp_unpacked_t      b_u_reg, b_u_next;
    logic              z_sign_reg, z_sign_next;
    logic signed [9:0] z_e_reg, z_e_next;
    logic [23:0]       z_m_reg, z_m_next;
    logic              guard_reg, guard_next;
    logic              round_reg, round_next;
    logic              sticky_reg, sticky_next;
    logic              flush_reg, flush_next;
    logic [31:0]       z_out_reg, z_out_next;
    logic              z_stb_reg, z_stb_next;

    logic [31:0]       op_raw  [2];
    fp_unpacked_t      op_unp  [2];
    logic              op_nan  [2];
    logic              op_inf  [2];
    logic              op_zero [2];

    logic [47:0]       prod;
    logic              res_sign;

    assign op_raw[0] = a_raw_reg;
    assign op_raw[1] = b_raw_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            fpu_unpack u_unpack (
                .value   (op_raw[gi]),
                .fields  (op_unp[gi]),
                .is_nan  (op_nan[gi]),
                .is_inf  (op_inf[gi]),
                .is_zero (op_zero[gi])
            );
        end
    endgenerate

    assign prod     = {24'd0, a_u_reg.mant} * {24'd0, b_u_reg.mant};
    assign res_sign = op_unp[0].sign ^ op_unp[1].sign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= GET_A;
            a_raw_reg  <= '0;
            b_raw_reg  <= '0;
            a_ack_reg  <= 1'b0;
            b_ack_reg  <= 1'b0;
            a_u_reg    <= '0;
            b_u_reg    <= '0;
            z_sign_reg <= 1'b0;
            z_e_reg    <= '0;
            z_m_reg    <= '0;
            guard_reg  <= 1'b0;
            round_reg  <= 1'b0;
            sticky_reg <= 1'b0;
            flush_reg  <= 1'b0;
            z_out_reg  <= '0;
            z_stb_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_raw_reg  <= a_raw_next;
            b_raw_reg  <= b_raw_next;
            a_ack_reg  <= a_ack_next;
            b_ack_reg  <= b_ack_next;
            a_u_reg    <= a_u_next;
            b_u_reg    <= b_u_next;
            z_sign_reg <= z_sign_next;
            z_e_reg    <= z_e_next;
            z_m_reg    <= z_m_next;
            guard_reg  <= guard_next;
            round_reg  <= round_next;
            sticky_reg <= sticky_next;
            flush_reg  <= flush_next;
            z_out_reg  <= z_out_next;
            z_stb_reg  <= z_stb_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_raw_next  = a_raw_reg;
        b_raw_next  = b_raw_reg;
        a_ack_next  = a_ack_reg;
        b_ack_next  = b_ack_reg;
        a_u_next    = a_u_reg;
        b_u_next    = b_u_reg;
        z_sign_next = z_sign_reg;
        z_e_next    = z_e_reg;
        z_m_next    = z_m_reg;
        guard_next  = guard_reg;
        round_next  = round_reg;
        sticky_next = sticky_reg;
        flush_next  = flush_reg;
        z_out_next  = z_out_reg;
        z_stb_next  = z_stb_reg;

        case (state_reg)
            GET_A: begin
                if (a_ack_reg && input_a_stb) begin
                    a_raw_next = input_a;
                    a_ack_next = 1'b0;
                    b_ack_next = 1'b1;
                    state_next = GET_B;
                end else begin
                    a_ack_next = 1'b1;
                end
            end
            GET_B: begin
                if (b_ack_reg && input_b_stb) begin
                    b_raw_next = input_b;
                    b_ack_next = 1'b0;
                    state_next = UNPACK;
                end else begin
                    b_ack_next = 1'b1;
                end
            end
            UNPACK: begin
                a_u_next   = op_unp[0];
                b_u_next   = op_unp[1];
                flush_next = 1'b0;
                state_next = SPECIAL;
            end
            SPECIAL: begin
                z_sign_next = res_sign;
                state_next  = PUT_Z;
                z_stb_next  = 1'b1;
                if (op_nan[0] || op_nan[1]) begin
                    z_out_next = FP_QNAN;
                end else if ((op_inf[0] && op_zero[1]) || (op_inf[1] && op_zero[0])) begin
                    z_out_next = FP_QNAN;
                end else if (op_inf[0] || op_inf[1]) begin
                    z_out_next = FP_INF | {res_sign, 31'd0};
                end else if (op_zero[0] || op_zero[1]) begin
                    z_out_next = {res_sign, 31'd0};
                end else begin
                    z_stb_next = 1'b0;
                    state_next = NORM_A;
                end
            end
            NORM_A: begin
                state_next = NORM_B;
`ifdef FPU_MUL_DENORM_EN
                if (!a_u_reg.mant[23]) begin
                    a_u_next.mant = {a_u_reg.mant[22:0], 1'b0};
                    a_u_next.exp  = a_u_reg.exp - 10'sd1;
                    state_next    = NORM_A;
                end
`endif
            end
            NORM_B: begin
                state_next = MUL;
`ifdef FPU_MUL_DENORM_EN
                if (!b_u_reg.mant[23]) begin
                    b_u_next.mant = {b_u_reg.mant[22:0], 1'b0};
                    b_u_next.exp  = b_u_reg.exp - 10'sd1;
                    state_next    = NORM_B;
                end
`endif
            end
            MUL: begin
                z_e_next    = a_u_reg.exp + b_u_reg.exp + 10'sd1;
                z_m_next    = prod[47:24];
                guard_next  = prod[23];
                round_next  = prod[22];
                sticky_next = |prod[21:0];
                state_next  = NORM_1;
            end
            NORM_1: begin
                // Both mantissas are normalised here, so at most one shift is ever needed
                if (!z_m_reg[23]) begin
                    z_m_next   = {z_m_reg[22:0], guard_reg};
                    guard_next = round_reg;
                    round_next = 1'b0;
                    z_e_next   = z_e_reg - 10'sd1;
                end
                state_next = NORM_2;
            end
            NORM_2: begin
                state_next = ROUND;
`ifdef FPU_MUL_DENORM_EN
                if (z_e_reg < EXP_MIN_W) begin
                    z_m_next    = {1'b0, z_m_reg[23:1]};
                    z_e_next    = z_e_reg + 10'sd1;
                    guard_next  = z_m_reg[0];
                    round_next  = guard_reg;
                    sticky_next = sticky_reg | round_reg;
                    state_next  = NORM_2;
                end
`else
                flush_next = (z_e_reg < EXP_MIN_W);
`endif
            end
            ROUND: begin
                if (guard_reg && (round_reg || sticky_reg || z_m_reg[0])) begin
                    if (z_m_reg == 24'hFFFFFF) begin
                        z_m_next = 24'h800000;
                        z_e_next = z_e_reg + 10'sd1;
                    end else begin
                        z_m_next = z_m_reg + 24'd1;
                    end
                end
                state_next = PACK;
            end
            PACK: begin
                if (flush_reg) begin
                    z_out_next = {z_sign_reg, 31'd0};
                end else if (z_e_reg > EXP_MAX_W) begin
                    z_out_next = FP_INF | {z_sign_reg, 31'd0};
                end else if ((z_e_reg == EXP_MIN_W) && !z_m_reg[23]) begin
                    z_out_next = {z_sign_reg, 8'h00, z_m_reg[22:0]};
                end else begin
                    z_out_next = {z_sign_reg, 8'(z_e_reg + EXP_BIAS_W), z_m_reg[22:0]};
                end
                z_stb_next = 1'b1;
                state_next = PUT_Z;
            end
            PUT_Z: begin
                if (z_stb_reg && output_z_ack) begin
                    z_stb_next = 1'b0;
                    a_ack_next = 1'b1;
                    state_next = GET_A;
                end
            end
            default: begin
                state_next = GET_A;
            end
        endcase
    end

    assign input_a_ack  = a_ack_reg;
    assign input_b_ack  = b_ack_reg;
    assign output_z     = z_out_reg;
    assign output_z_stb = z_stb_reg;

endmodule

// File: tb/tb_fpu_multiplier.sv
// Directed-vector bench for fpu_multiplier: arithmetic, latency, backpressure,
// specials, overflow/underflow, rounding and back-to-back with a reset pulse.
module tb_fpu_multiplier;

    logic        clk;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int tests_run;
    int tests_failed;
    int a_hs;
    int b_hs;

    fpu_multiplier dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (input_a_stb && input_a_ack) a_hs++;
        if (input_b_stb && input_b_ack) b_hs++;
    end

    // Hands A then B to the DUT and returns once output_z_stb is seen;
    // lat counts edges from the B-accepting edge to the strobe.
    task automatic send_ab(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output bit timeout);
        int n;
        timeout = 1'b0;
        lat = 0;
        input_a = a;
        input_a_stb = 1'b1;
        n = 0;
        while (!input_a_ack && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!input_a_ack) timeout = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        input_b = b;
        input_b_stb = 1'b1;
        n = 0;
        while (!input_b_ack && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!input_b_ack) timeout = 1'b1;
        @(posedge clk); #1;
        input_b_stb = 1'b0;
        while (!output_z_stb && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        if (!output_z_stb) timeout = 1'b1;
    endtask

    task automatic take_z(output logic [31:0] z);
        z = output_z;
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (input_a_ack !== 1'b0 || input_b_ack !== 1'b0 || output_z_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: a_ack=%b b_ack=%b z_stb=%b, required 0 0 0",
                     input_a_ack, input_b_ack, output_z_stb);
        end
        tests_run++;
        if (output_z !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_output_z: got %h, required 00000000", output_z);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (input_a_ack !== 1'b1 || input_b_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_get_a: a_ack=%b b_ack=%b, required 1 0", input_a_ack, input_b_ack);
        end
    endtask

    task automatic test_arith;
        logic [31:0] av [6];
        logic [31:0] bv [6];
        logic [31:0] ev [6];
        logic [31:0] z;
        int lat;
        bit to;
        int a0, b0;
        av[0] = 32'h3F800000; bv[0] = 32'hC0800000; ev[0] = 32'hC0800000;
        av[1] = 32'h40000000; bv[1] = 32'h40400000; ev[1] = 32'h40C00000;
        av[2] = 32'hC0400000; bv[2] = 32'h40000000; ev[2] = 32'hC0C00000;
        av[3] = 32'hC0800000; bv[3] = 32'hBF800000; ev[3] = 32'h40800000;
        av[4] = 32'h40A00000; bv[4] = 32'h40A00000; ev[4] = 32'h41C80000;
        av[5] = 32'h40E00000; bv[5] = 32'h40E00000; ev[5] = 32'h42440000;
        a0 = a_hs;
        b0 = b_hs;
        for (int i = 0; i < 6; i++) begin
            send_ab(av[i], bv[i], lat, to);
            take_z(z);
            tests_run++;
            if (to || z !== ev[i]) begin
                tests_failed++;
                $display("FAIL arith_%0d: %h*%h got %h (timeout=%0d), required %h",
                         i, av[i], bv[i], z, to, ev[i]);
            end
            tests_run++;
            if (lat != 9) begin
                tests_failed++;
                $display("FAIL latency_%0d: got %0d edges, required 9", i, lat);
            end
        end
        tests_run++;
        if (a_hs - a0 != 6 || b_hs - b0 != 6) begin
            tests_failed++;
            $display("FAIL ack_once: a handshakes %0d b handshakes %0d, required 6 6",
                     a_hs - a0, b_hs - b0);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] z;
        int lat;
        bit to;
        int bad_stb, bad_z, bad_ack;
        send_ab(32'h40000000, 32'h40400000, lat, to);
        bad_stb = 0; bad_z = 0; bad_ack = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (output_z_stb !== 1'b1) bad_stb++;
            if (output_z !== 32'h40C00000) bad_z++;
            if (input_a_ack !== 1'b0) bad_ack++;
        end
        tests_run++;
        if (to || bad_stb != 0) begin
            tests_failed++;
            $display("FAIL bp_stb: %0d cycles with stb low (timeout=%0d), required 0", bad_stb, to);
        end
        tests_run++;
        if (bad_z != 0) begin
            tests_failed++;
            $display("FAIL bp_z_stable: %0d cycles with z != 40c00000, required 0", bad_z);
        end
        tests_run++;
        if (bad_ack != 0) begin
            tests_failed++;
            $display("FAIL bp_a_ack: %0d cycles with a_ack high, required 0", bad_ack);
        end
        take_z(z);
        #1;
        tests_run++;
        if (z !== 32'h40C00000 || output_z_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: z=%h stb=%b, required 40c00000 0", z, output_z_stb);
        end
    endtask

    task automatic test_specials;
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [31:0] ev [4];
        logic [31:0] z;
        int lat;
        bit to;
        av[0] = 32'h7F800000; bv[0] = 32'h00000000; ev[0] = 32'h7FC00000;
        av[1] = 32'hFF800000; bv[1] = 32'h40000000; ev[1] = 32'hFF800000;
        av[2] = 32'h80000000; bv[2] = 32'h40400000; ev[2] = 32'h80000000;
        av[3] = 32'h7FC00000; bv[3] = 32'h3F800000; ev[3] = 32'h7FC00000;
        for (int i = 0; i < 4; i++) begin
            send_ab(av[i], bv[i], lat, to);
            take_z(z);
            tests_run++;
            if (to || z !== ev[i] || lat != 2) begin
                tests_failed++;
                $display("FAIL special_%0d: %h*%h got %h lat %0d (timeout=%0d), required %h lat 2",
                         i, av[i], bv[i], z, lat, to, ev[i]);
            end
        end
    endtask

    task automatic test_range;
        logic [31:0] z;
        logic [31:0] exp_under;
        int lat;
        int exp_lat;
        bit to;
        send_ab(32'h7F7FFFFF, 32'h40000000, lat, to);
        take_z(z);
        tests_run++;
        if (to || z !== 32'h7F800000) begin
            tests_failed++;
            $display("FAIL overflow: got %h (timeout=%0d), required 7f800000", z, to);
        end
`ifdef FPU_MUL_DENORM_EN
        exp_under = 32'h00400000;
        exp_lat = 10;
`else
        exp_under = 32'h00000000;
        exp_lat = 9;
`endif
        send_ab(32'h00800000, 32'h3F000000, lat, to);
        take_z(z);
        tests_run++;
        if (to || z !== exp_under || lat != exp_lat) begin
            tests_failed++;
            $display("FAIL underflow: got %h lat %0d (timeout=%0d), required %h lat %0d",
                     z, lat, to, exp_under, exp_lat);
        end
    endtask

    task automatic test_rounding;
        logic [31:0] z;
        int lat;
        bit to;
        send_ab(32'h3F800001, 32'h3F800001, lat, to);
        take_z(z);
        tests_run++;
        if (to || z !== 32'h3F800002) begin
            tests_failed++;
            $display("FAIL round_sticky: got %h (timeout=%0d), required 3f800002", z, to);
        end
        send_ab(32'h3FFFFFFF, 32'h3FFFFFFF, lat, to);
        take_z(z);
        tests_run++;
        if (to || z !== 32'h407FFFFE) begin
            tests_failed++;
            $display("FAIL round_max: got %h (timeout=%0d), required 407ffffe", z, to);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [31:0] ev [4];
        int idx;
        int cycles;
        int spurious;
        av[0] = 32'h3FC00000; bv[0] = 32'h40000000; ev[0] = 32'h40400000;
        av[1] = 32'hC0400000; bv[1] = 32'h40000000; ev[1] = 32'hC0C00000;
        av[2] = 32'h40E00000; bv[2] = 32'h40E00000; ev[2] = 32'h42440000;
        av[3] = 32'h40000000; bv[3] = 32'h40400000; ev[3] = 32'h40C00000;
        idx = 0;
        cycles = 0;
        input_a = av[0];
        input_b = bv[0];
        input_a_stb = 1'b1;
        input_b_stb = 1'b1;
        output_z_ack = 1'b1;
        while (idx < 4 && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (output_z_stb) begin
                tests_run++;
                if (output_z !== ev[idx]) begin
                    tests_failed++;
                    $display("FAIL b2b_%0d: got %h, required %h", idx, output_z, ev[idx]);
                end
                idx++;
                @(posedge clk); #1;
                if (idx < 4) begin
                    input_a = av[idx];
                    input_b = bv[idx];
                end
            end
        end
        tests_run++;
        if (idx != 4) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results, required 4", idx);
        end
        // Another 2*3 is now in flight; kill it with an asynchronous reset
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if (input_a_ack !== 1'b0 || input_b_ack !== 1'b0 || output_z_stb !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_async: a_ack=%b b_ack=%b z_stb=%b, required 0 0 0",
                     input_a_ack, input_b_ack, output_z_stb);
        end
        input_a = 32'h40E00000;
        input_b = 32'h40E00000;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (output_z_stb) spurious++;
        end
        tests_run++;
        if (spurious != 0) begin
            tests_failed++;
            $display("FAIL midreset_spurious: %0d early strobes, required 0", spurious);
        end
        cycles = 0;
        while (!output_z_stb && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        tests_run++;
        if (output_z_stb !== 1'b1 || output_z !== 32'h42440000) begin
            tests_failed++;
            $display("FAIL midreset_result: stb=%b z=%h, required 1 42440000", output_z_stb, output_z);
        end
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        a_hs = 0;
        b_hs = 0;
        rst = 1'b0;
        input_a = '0;
        input_b = '0;
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        output_z_ack = 1'b0;
        test_reset();
        test_arith();
        test_backpressure();
        test_specials();
        test_range();
        test_rounding();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
